// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   EX-stage front end for the combinational ALU. Decodes ALUOp/funct into the
//   4-bit ALU opcode and registers the operands, one instruction per cycle.
//   Also owns a multi-cycle signed shift-add MULT engine and the HI/LO registers.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   valid_in / ready      upstream handshake; accept on valid_in && ready
//   alu_op, funct         main-control ALUOp and R-type function field
//   a_in, b_in            signed operands
//   opcode, a_out, b_out  registered ALU opcode and operands
//   valid_out             opcode/a_out/b_out carry a valid operation this cycle
//   hi, lo                HI/LO registers, written when a MULT completes
//   mult_busy             multiply in progress
//
// state | meaning
// IDLE  | accepting instructions, ready = 1
// MULT  | one shift-add step per cycle, WORD_WIDTH steps
// DONE  | sign-correct the product and write HI/LO
module alu_issue_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready,
  input  logic [1:0]            alu_op,
  input  logic [5:0]            funct,
  input  logic [WORD_WIDTH-1:0] a_in,
  input  logic [WORD_WIDTH-1:0] b_in,
  output logic [3:0]            opcode,
  output logic [WORD_WIDTH-1:0] a_out,
  output logic [WORD_WIDTH-1:0] b_out,
  output logic                  valid_out,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo,
  output logic                  mult_busy
);

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int PW = 2 * WORD_WIDTH;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_PASS = 4'b1111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [WORD_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WORD_WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  sign_q, sign_d;

  logic                  accept;
  logic [WORD_WIDTH-1:0] a_mag, b_mag;
  logic [CW-1:0]         shamt;
  logic [PW-1:0]         mcand_shifted;
  logic [PW-1:0]         prod_signed;

  assign ready     = (state_q == S_IDLE);
  assign mult_busy = (state_q != S_IDLE);
  assign accept    = valid_in && ready;

  // Magnitudes are unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
  assign a_mag = a_in[WORD_WIDTH-1] ? (~a_in + WORD_WIDTH'(1)) : a_in;
  assign b_mag = b_in[WORD_WIDTH-1] ? (~b_in + WORD_WIDTH'(1)) : b_in;

  // count runs WORD_WIDTH..1, so the step index is WORD_WIDTH - count.
  assign shamt         = CW'(WORD_WIDTH) - count_q;
  assign mcand_shifted = {{WORD_WIDTH{1'b0}}, mcand_q} << shamt;
  assign prod_signed   = sign_q ? (~prod_q + PW'(1)) : prod_q;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    sign_d   = sign_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (alu_op == 2'b10 && funct == FN_MULT) begin
            state_d  = S_MULT;
            mcand_d  = a_mag;
            mplier_d = b_mag;
            sign_d   = a_in[WORD_WIDTH-1] ^ b_in[WORD_WIDTH-1];
            prod_d   = '0;
            count_d  = CW'(WORD_WIDTH);
          end else begin
            valid_d  = 1'b1;
            a_d      = a_in;
            b_d      = b_in;
            opcode_d = OP_PASS;
            case (alu_op)
              2'b00: opcode_d = OP_ADD;
              2'b01: opcode_d = OP_SUB;
              2'b10: begin
                case (funct)
                  FN_ADD:  opcode_d = OP_ADD;
                  FN_SUB:  opcode_d = OP_SUB;
                  FN_AND:  opcode_d = OP_AND;
                  FN_OR:   opcode_d = OP_OR;
                  FN_NOR:  opcode_d = OP_NOR;
                  FN_MFHI: begin
                    a_d = hi_q;
                    b_d = '0;
                  end
                  FN_MFLO: begin
                    a_d = lo_q;
                    b_d = '0;
                  end
                  default: opcode_d = OP_PASS;
                endcase
              end
              default: opcode_d = OP_PASS;
            endcase
          end
        end
      end

      S_MULT: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_shifted;
        end
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        hi_d    = prod_signed[PW-1:WORD_WIDTH];
        lo_d    = prod_signed[WORD_WIDTH-1:0];
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_PASS;
      a_q      <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
    end
  end

  assign opcode    = opcode_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign valid_out = valid_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- EX-stage front end of the datapath ALU: decodes ALUOp/funct into the ALU's 4-bit opcode and presents registered operands to the ALU, one instruction per cycle.
- Also owns the multi-cycle signed MULT engine and the HI/LO registers. MFHI/MFLO are routed through the ALU's pass-through (default) opcode.
- Sits between the ID/EX pipeline register and the combinational ALU. It stalls upstream while a multiply is in progress.

Parameters:
- WORD_WIDTH, 32, operand, result and HI/LO width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  upstream instruction valid.
- ready  output  1  block accepts an instruction this cycle.
- alu_op  input  2  main-control ALUOp: 00 = load/store, 01 = branch, 10 = R-type, 11 = reserved.
- funct  input  6  R-type function field.
- a_in  input  WORD_WIDTH  signed operand A (rs).
- b_in  input  WORD_WIDTH  signed operand B (rt or sign-extended immediate).
- opcode  output  4  ALU opcode, registered.
- a_out  output  WORD_WIDTH  ALU a_input, registered.
- b_out  output  WORD_WIDTH  ALU b_input, registered.
- valid_out  output  1  opcode/a_out/b_out hold a valid ALU operation.
- hi  output  WORD_WIDTH  HI register.
- lo  output  WORD_WIDTH  LO register.
- mult_busy  output  1  multiply in progress.

Behaviour:
- Reset (synchronous, active-high) clears every output: opcode = 4'b1111, a_out = b_out = hi = lo = 0, valid_out = 0, mult_busy = 0. State goes to IDLE and ready = 1 in the cycle after reset.
- reset asserted mid-multiply aborts the multiply; HI/LO go to 0.

Handshake:
- An instruction is accepted on a rising edge where valid_in && ready.
- ready = (state == IDLE) and is purely combinational from state.
- Upstream holds its inputs while ready = 0.

Decode (applied at accept; results registered, 1-cycle latency to the ALU):
- alu_op = 00: opcode 0010 (add).
- alu_op = 01: opcode 0110 (subtract).
- alu_op = 10, funct 100000: 0010 (add).
- alu_op = 10, funct 100010: 0110 (subtract).
- alu_op = 10, funct 100100: 0000 (and).
- alu_op = 10, funct 100101: 0001 (or).
- alu_op = 10, funct 100111: 1100 (nor).
- alu_op = 10, funct 010000 (MFHI): opcode 1111, a_out = hi, b_out = 0.
- alu_op = 10, funct 010010 (MFLO): opcode 1111, a_out = lo, b_out = 0.
- alu_op = 10, funct 011000 (MULT): enter the MULT state; no ALU operation is issued.
- Any other funct, and alu_op = 11: opcode 1111 with a_out = a_in. valid_out is still 1.
- For every non-MULT accept: a_out = a_in and b_out = b_in unless stated otherwise; valid_out = 1 on the next cycle.
- A cycle with no accept drives valid_out = 0 next cycle; opcode, a_out and b_out hold their values.

State machine (IDLE, MULT, DONE):
- IDLE → MULT on accept of MULT.
  - Latch |a_in| and |b_in| magnitudes and the result sign (a_in[MSB] ^ b_in[MSB]).
  - Clear the 2×WORD_WIDTH product accumulator and load the count with WORD_WIDTH.
- MULT: one shift-add step per cycle.
  - If multiplier LSB = 1, add the multiplicand shifted by (WORD_WIDTH − count) into the product.
  - Shift the multiplier right and decrement the count.
  - Go to DONE when the count reaches 0.
  - mult_busy = 1, ready = 0.
- DONE: write hi/lo = the 2×WORD_WIDTH signed product, two's-complement negated if the sign bit is set. hi = upper word, lo = lower word. mult_busy = 1, ready = 0, then → IDLE.
- Total MULT occupancy: WORD_WIDTH + 1 cycles after accept (33 for the default). hi/lo are visible on the edge that leaves DONE.
- Magnitude of the most negative value (−2^(WORD_WIDTH−1)) is taken as an unsigned WORD_WIDTH value; the product is correct, including (−2^31) × (−2^31) = 2^62.
- valid_out = 0 throughout MULT and DONE. opcode, a_out and b_out hold.
- An MFHI/MFLO issued right after a MULT is held off by ready = 0, so it always reads the new hi/lo.
- hi/lo change only at DONE and at reset.

Test Plan:
- Reset with valid_in = 1 → opcode = 1111, a_out = b_out = hi = lo = 0, valid_out = 0; ready = 1 the cycle after reset releases.
- Back-to-back accepts: R-type funct 100000, 100010, 100111, then alu_op = 01, with a_in = 5, b_in = 3 → opcodes 0010, 0110, 1100, 0110 on consecutive cycles, each 1 cycle after accept; valid_out = 1 each cycle; a_out = 5, b_out = 3.
- MULT a_in = −7, b_in = 6 → ready = 0 for exactly 33 cycles; then hi = 32'hFFFFFFFF, lo = 32'hFFFFFFD6 (−42); valid_out = 0 throughout.
- MULT 32'h80000000 × 32'h80000000 → hi = 32'h40000000, lo = 0.
- MULT then immediate MFLO held at valid_in (a_in = 9, b_in = 9, result 81) → MFLO accepted on the first ready = 1 cycle; next cycle opcode = 1111, a_out = 81, b_out = 0.
- Reset asserted at cycle 10 of a MULT → hi = lo = 0, ready = 1 and mult_busy = 0 after release; a subsequent funct 100101 issues opcode 0001.
